// File: rtl/matrix_host_pkg.sv
// Shared types and sizing helpers for the matrix host sequencer.
package matrix_host_pkg;

   typedef enum logic [2:0] {
      StLoadA,
      StLoadB,
      StStart,
      StWait,
      StDrain
   } state_e;

   // Default job geometry and the widths derived from it.
   localparam int unsigned M_DEF  = 3;
   localparam int unsigned N_DEF  = 3;
   localparam int unsigned P_DEF  = 3;
   localparam int unsigned DW_DEF = 8;

   localparam int unsigned A_AW  = $clog2(M_DEF * N_DEF);
   localparam int unsigned B_AW  = $clog2(N_DEF * P_DEF);
   localparam int unsigned R_AW  = $clog2(M_DEF * P_DEF + 1);
   localparam int unsigned RES_W = 2 * DW_DEF;

   // Address width for a given depth, never narrower than one bit.
   function automatic int unsigned clog2_w(input int unsigned v);
      return (v <= 1) ? 1 : $clog2(v);
   endfunction

endpackage

// File: rtl/matrix_result_buffer.sv
// Result capture store: one synchronous write port, one combinational read port.
module matrix_result_buffer #(
   parameter int unsigned DEPTH = 9,
   parameter int unsigned WIDTH = 16,
   parameter int unsigned AW    = 4
) (
   input  logic             clk,
   input  logic             wen,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Contents are intentionally left unreset.
   always_ff @(posedge clk) begin
      if (wen) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = (int'(raddr) < DEPTH) ? mem[raddr] : '0;

endmodule

// File: rtl/matrix_host_sequencer.sv
// Host-side initiator for the matrix accelerator: loads A/B, starts, captures and
// streams back the result beats, and flags short, overflowing or timed-out jobs.
module matrix_host_sequencer
   import matrix_host_pkg::*;
#(
   parameter int unsigned M              = M_DEF,
   parameter int unsigned N              = N_DEF,
   parameter int unsigned P              = P_DEF,
   parameter int unsigned DATA_WIDTH     = DW_DEF,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [DATA_WIDTH-1:0]       in_data,
   input  logic [1:0]                  app_sel,
   output logic [1:0]                  app_select,
   output logic [DATA_WIDTH-1:0]       a_data_in,
   output logic [clog2_w(M*N)-1:0]     a_addr,
   output logic                        a_wen,
   output logic [DATA_WIDTH-1:0]       b_data_in,
   output logic [clog2_w(N*P)-1:0]     b_addr,
   output logic                        b_wen,
   output logic                        start_computation,
   input  logic                        computation_done,
   input  logic [2*DATA_WIDTH-1:0]     result_out,
   input  logic                        result_valid,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [2*DATA_WIDTH-1:0]     out_data,
   output logic                        out_last,
   output logic                        busy,
   output logic                        err_short,
   output logic                        err_overflow,
   output logic                        err_timeout
);

   localparam int unsigned a_aw  = clog2_w(M * N);
   localparam int unsigned b_aw  = clog2_w(N * P);
   localparam int unsigned r_aw  = clog2_w(M * P + 1);
   localparam int unsigned res_w = 2 * DATA_WIDTH;
   localparam int unsigned cnt_w = (a_aw > b_aw) ? a_aw : b_aw;
   localparam int unsigned t_w   = clog2_w(TIMEOUT_CYCLES);

   localparam logic [cnt_w-1:0] a_last = cnt_w'(M * N - 1);
   localparam logic [cnt_w-1:0] b_last = cnt_w'(N * P - 1);
   localparam logic [r_aw-1:0]  r_full = r_aw'(M * P);
   localparam logic [t_w-1:0]   t_last = t_w'(TIMEOUT_CYCLES - 1);

   state_e state_q, state_d;

   logic [cnt_w-1:0]      count_q;
   logic [r_aw-1:0]       rcount_q, rd_ptr_q, rcount_next;
   logic [t_w-1:0]        timer_q;
   logic                  a_wen_q, b_wen_q, start_q, busy_q;
   logic [a_aw-1:0]       a_addr_q;
   logic [b_aw-1:0]       b_addr_q;
   logic [DATA_WIDTH-1:0] a_data_q, b_data_q;
   logic [1:0]            app_select_q;
   logic                  err_short_q, err_overflow_q, err_timeout_q;
   logic                  accept, cap, ovf, hs;
   logic [res_w-1:0]      rd_data;

   assign in_ready    = ((state_q == StLoadA) || (state_q == StLoadB)) && !rst;
   assign accept      = in_valid && in_ready;
   assign cap         = (state_q == StWait) && result_valid && (rcount_q < r_full);
   assign ovf         = (state_q == StWait) && result_valid && (rcount_q == r_full);
   assign rcount_next = rcount_q + r_aw'(cap);

   assign out_valid = (state_q == StDrain) && (rd_ptr_q < rcount_q);
   assign out_last  = out_valid && (rd_ptr_q == rcount_q - r_aw'(1));
   assign out_data  = out_valid ? rd_data : '0;
   assign hs        = out_valid && out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StLoadA;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StLoadA: if (accept && count_q == a_last) state_d = StLoadB;
         StLoadB: if (accept && count_q == b_last) state_d = StStart;
         StStart: state_d = StWait;
         StWait:  if (computation_done || timer_q == t_last) state_d = StDrain;
         StDrain: begin
            if (rcount_q == '0 || (hs && rd_ptr_q == rcount_q - r_aw'(1))) begin
               state_d = StLoadA;
            end
         end
         default: state_d = StLoadA;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q        <= '0;
         a_wen_q        <= 1'b0;
         a_addr_q       <= '0;
         a_data_q       <= '0;
         b_wen_q        <= 1'b0;
         b_addr_q       <= '0;
         b_data_q       <= '0;
         start_q        <= 1'b0;
         app_select_q   <= '0;
         busy_q         <= 1'b0;
         err_short_q    <= 1'b0;
         err_overflow_q <= 1'b0;
         err_timeout_q  <= 1'b0;
         rcount_q       <= '0;
         rd_ptr_q       <= '0;
         timer_q        <= '0;
      end else begin
         a_wen_q <= 1'b0;
         b_wen_q <= 1'b0;
         start_q <= 1'b0;
         if (accept) begin
            count_q <= (state_d != state_q) ? '0 : count_q + cnt_w'(1);
            if (state_q == StLoadA) begin
               a_wen_q  <= 1'b1;
               a_addr_q <= count_q[a_aw-1:0];
               a_data_q <= in_data;
               // First A beat opens a new job.
               if (count_q == '0) begin
                  app_select_q   <= app_sel;
                  busy_q         <= 1'b1;
                  err_short_q    <= 1'b0;
                  err_overflow_q <= 1'b0;
                  err_timeout_q  <= 1'b0;
               end
            end else begin
               b_wen_q  <= 1'b1;
               b_addr_q <= count_q[b_aw-1:0];
               b_data_q <= in_data;
            end
         end
         if (state_q == StStart) begin
            start_q <= 1'b1;
            timer_q <= '0;
         end
         if (state_q == StWait) begin
            rcount_q <= rcount_next;
            if (ovf) err_overflow_q <= 1'b1;
            // A beat coinciding with done is counted before the short check.
            if (computation_done) begin
               if (rcount_next < r_full) err_short_q <= 1'b1;
            end else if (timer_q == t_last) begin
               err_timeout_q <= 1'b1;
            end else begin
               timer_q <= timer_q + t_w'(1);
            end
         end
         if (state_q == StDrain) begin
            if (hs) rd_ptr_q <= rd_ptr_q + r_aw'(1);
            if (state_d == StLoadA) begin
               rcount_q <= '0;
               rd_ptr_q <= '0;
               busy_q   <= 1'b0;
            end
         end
      end
   end

   matrix_result_buffer #(
      .DEPTH (M * P),
      .WIDTH (res_w),
      .AW    (r_aw)
   ) u_res_buf (
      .clk   (clk),
      .wen   (cap),
      .waddr (rcount_q),
      .wdata (result_out),
      .raddr (rd_ptr_q),
      .rdata (rd_data)
   );

   assign a_wen             = a_wen_q;
   assign a_addr            = a_addr_q;
   assign a_data_in         = a_data_q;
   assign b_wen             = b_wen_q;
   assign b_addr            = b_addr_q;
   assign b_data_in         = b_data_q;
   assign start_computation = start_q;
   assign app_select        = app_select_q;
   assign busy              = busy_q;
   assign err_short         = err_short_q;
   assign err_overflow      = err_overflow_q;
   assign err_timeout       = err_timeout_q;

endmodule

// File: tb/tb_matrix_host_sequencer.sv
// Randomized bench: an accelerator model fed from the captured A/B writes, with the
// result stream checked against a matrix product computed from the operand stream.
module tb_matrix_host_sequencer;

   localparam int M = 3;
   localparam int N = 3;
   localparam int P = 3;
   localparam int TMO = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready;
   logic [7:0]  in_data;
   logic [1:0]  app_sel, app_select;
   logic [7:0]  a_data_in, b_data_in;
   logic [3:0]  a_addr, b_addr;
   logic        a_wen, b_wen, start_computation, computation_done;
   logic [15:0] result_out, out_data;
   logic        result_valid, out_valid, out_ready, out_last, busy;
   logic        err_short, err_overflow, err_timeout;

   matrix_host_sequencer #(
      .M (M), .N (N), .P (P), .DATA_WIDTH (8), .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk (clk), .rst (rst),
      .in_valid (in_valid), .in_ready (in_ready), .in_data (in_data),
      .app_sel (app_sel), .app_select (app_select),
      .a_data_in (a_data_in), .a_addr (a_addr), .a_wen (a_wen),
      .b_data_in (b_data_in), .b_addr (b_addr), .b_wen (b_wen),
      .start_computation (start_computation), .computation_done (computation_done),
      .result_out (result_out), .result_valid (result_valid),
      .out_valid (out_valid), .out_ready (out_ready), .out_data (out_data),
      .out_last (out_last), .busy (busy),
      .err_short (err_short), .err_overflow (err_overflow), .err_timeout (err_timeout)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   // Operand stream of the current job, and the accelerator's view of its memories.
   logic [7:0] opa [9];
   logic [7:0] opb [9];
   logic [7:0] mem_a [16];
   logic [7:0] mem_b [16];
   logic [3:0] la_addr [256];
   logic [7:0] la_data [256];
   logic [3:0] lb_addr [256];
   logic [7:0] lb_data [256];
   int wa_idx = 0;
   int wb_idx = 0;
   int start_cnt = 0;

   always @(negedge clk) begin
      if (a_wen) begin
         la_addr[wa_idx % 256] <= a_addr;
         la_data[wa_idx % 256] <= a_data_in;
         mem_a[a_addr] <= a_data_in;
         wa_idx <= wa_idx + 1;
      end
      if (b_wen) begin
         lb_addr[wb_idx % 256] <= b_addr;
         lb_data[wb_idx % 256] <= b_data_in;
         mem_b[b_addr] <= b_data_in;
         wb_idx <= wb_idx + 1;
      end
      if (start_computation) start_cnt <= start_cnt + 1;
   end

   function automatic logic [15:0] ref_c(input int j);
      int s = 0;
      for (int k = 0; k < N; k++) s += int'(opa[(j / P) * N + k]) * int'(opb[k * P + (j % P)]);
      return s[15:0];
   endfunction

   function automatic logic [15:0] model_c(input int j);
      int s = 0;
      for (int k = 0; k < N; k++) s += int'(mem_a[(j / P) * N + k]) * int'(mem_b[k * P + (j % P)]);
      return s[15:0];
   endfunction

   // 0 always, 1 pattern 1,0,0,1, 2 toggle 1,0, 3 random.
   function automatic bit pat(input int mode, input int c);
      case (mode)
         0: return 1'b1;
         1: return (c % 4 == 0) || (c % 4 == 3);
         2: return (c % 2 == 0);
         default: return $urandom_range(0, 1) == 1;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_zero(input string tag);
      check_eq(tag, {in_ready, a_wen, b_wen, start_computation, out_valid, out_last, busy,
                     err_short, err_overflow, err_timeout}, 0);
      check_eq({tag, "_bus"}, {app_select, a_addr, b_addr, a_data_in, b_data_in}, 0);
      check_eq({tag, "_out_data"}, out_data, 0);
   endtask

   task automatic run_job(input int n_emit, input bit give_done, input bit done_last,
                          input int in_mode, input int out_mode, input bit ident,
                          input int stop_at);
      int idx, cyc, k, got, exp_n, st0, wa0, wb0;
      logic [1:0]  sel;
      logic [15:0] held;
      bit hold, acc, r;
      for (int i = 0; i < 9; i++) begin
         opa[i] = ident ? ((i % 4 == 0) ? 8'd1 : 8'd0) : 8'($urandom_range(0, 255));
         opb[i] = ident ? ((i % 4 == 0) ? 8'd1 : 8'd0) : 8'($urandom_range(0, 255));
      end
      wa0 = wa_idx;
      wb0 = wb_idx;
      st0 = start_cnt;
      sel = 2'($urandom_range(0, 3));
      idx = 0;
      cyc = 0;
      while (idx < stop_at && cyc < 400) begin
         in_valid = pat(in_mode, cyc);
         in_data  = (idx < 9) ? opa[idx] : opb[idx - 9];
         app_sel  = (idx == 0) ? sel : 2'($urandom_range(0, 3));
         acc = in_valid && in_ready;
         tick();
         cyc++;
         if (acc) begin
            if (idx == 0) begin
               check_eq("app_latch", app_select, sel);
               check_eq("busy_set", busy, 1);
               check_eq("err_clear", {err_short, err_overflow, err_timeout}, 0);
            end
            idx++;
         end
      end
      in_valid = 1'b0;
      check_eq("load_beats", idx, stop_at);

      if (stop_at < 18) begin
         rst = 1'b1;
         #1;
         check_zero("rst_async");
         repeat (3) begin
            tick();
            check_zero("rst_hold");
         end
         rst = 1'b0;
         repeat (20) tick();
         check_eq("no_start_after_rst", start_cnt - st0, 0);
         check_eq("idle_after_rst", {out_valid, busy, in_ready}, 3'b001);
         return;
      end

      check_eq("start_low_in_start", start_computation, 0);
      tick();
      check_eq("start_pulse", start_computation, 1);
      k = 0;
      check_eq("a_count", wa_idx - wa0, 9);
      check_eq("b_count", wb_idx - wb0, 9);
      for (int i = 0; i < 9; i++) begin
         check_eq("a_addr", la_addr[(wa0 + i) % 256], i);
         check_eq("a_data", la_data[(wa0 + i) % 256], opa[i]);
         check_eq("b_addr", lb_addr[(wb0 + i) % 256], i);
         check_eq("b_data", lb_data[(wb0 + i) % 256], opb[i]);
      end

      for (int j = 0; j < n_emit; j++) begin
         result_valid = 1'b1;
         result_out = (j < 9) ? model_c(j) : 16'($urandom);
         computation_done = give_done && done_last && (j == n_emit - 1);
         tick();
         k++;
         if (j == 0) check_eq("start_single", start_computation, 0);
      end
      result_valid = 1'b0;
      computation_done = 1'b0;
      if (give_done && !done_last) begin
         computation_done = 1'b1;
         tick();
         k++;
         computation_done = 1'b0;
      end
      if (!give_done) begin
         while (k < TMO - 1) begin
            tick();
            k++;
         end
         check_eq("tmo_early", err_timeout, 0);
         tick();
         k++;
         check_eq("tmo_at_limit", err_timeout, 1);
      end

      exp_n = (n_emit < 9) ? n_emit : 9;
      got = 0;
      cyc = 0;
      hold = 1'b0;
      held = '0;
      while (got < exp_n && cyc < 200) begin
         r = pat(out_mode, cyc);
         out_ready = r;
         if (hold) begin
            check_eq("stall_valid", out_valid, 1);
            check_eq("stall_data", out_data, held);
            hold = 1'b0;
         end
         if (out_valid) begin
            if (r) begin
               check_eq("out_data", out_data, ref_c(got));
               check_eq("out_last", out_last, (got == exp_n - 1));
               got++;
            end else begin
               held = out_data;
               hold = 1'b1;
            end
         end
         tick();
         cyc++;
      end
      out_ready = 1'b0;
      check_eq("drain_count", got, exp_n);
      check_eq("idle_after_drain", {out_valid, busy, in_ready}, 3'b001);
      check_eq("err_short", err_short, give_done && n_emit < 9);
      check_eq("err_overflow", err_overflow, n_emit > 9);
      check_eq("err_timeout", err_timeout, !give_done);
      check_eq("app_hold", app_select, sel);
      check_eq("start_count", start_cnt - st0, 1);
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 1'b0;
      in_data = '0;
      app_sel = '0;
      computation_done = 1'b0;
      result_out = '0;
      result_valid = 1'b0;
      out_ready = 1'b0;
      repeat (2) tick();
      check_zero("reset");
      rst = 1'b0;
      tick();
      check_eq("ready_after_rst", in_ready, 1);

      run_job(9, 1, 0, 0, 0, 1, 18);   // identity, clean handshakes
      run_job(9, 1, 1, 1, 2, 0, 18);   // gappy input, toggling ready, done with last beat
      run_job(5, 1, 0, 3, 3, 0, 18);   // short result
      run_job(11, 1, 0, 0, 3, 0, 18);  // overflow
      run_job(2, 0, 0, 0, 0, 0, 18);   // timeout
      run_job(9, 1, 0, 0, 0, 0, 13);   // reset after 4 B beats
      run_job(9, 1, 0, 0, 0, 1, 18);   // identity after reset
      for (int i = 0; i < 3; i++) run_job(9, 1, 1'($urandom_range(0, 1)), 3, 3, 0, 18);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
